// File: rtl/ext_bus_target_pkg.sv
// Shared constants, state encoding and STATUS packing for the external bus target.
package ext_bus_target_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_IRQ_EN  = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned ST_H2L_FULL  = 0;
  localparam int unsigned ST_H2L_EMPTY = 1;
  localparam int unsigned ST_L2H_EMPTY = 2;
  localparam int unsigned ST_L2H_FULL  = 3;
  localparam int unsigned ST_OVF       = 4;
  localparam int unsigned ST_UDF       = 5;

  localparam int unsigned IE_L2H_AVAIL = 0;
  localparam int unsigned IE_H2L_EMPTY = 1;
  localparam int unsigned IE_ERR       = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic       h2l_full;
    logic       h2l_empty;
    logic       l2h_empty;
    logic       l2h_full;
    logic       ovf;
    logic       udf;
    logic [3:0] l2h_count;
  } status_t;

  function automatic logic [15:0] status_word(input status_t s);
    logic [15:0] w;
    w               = '0;
    w[ST_H2L_FULL]  = s.h2l_full;
    w[ST_H2L_EMPTY] = s.h2l_empty;
    w[ST_L2H_EMPTY] = s.l2h_empty;
    w[ST_L2H_FULL]  = s.l2h_full;
    w[ST_OVF]       = s.ovf;
    w[ST_UDF]       = s.udf;
    w[11:8]         = s.l2h_count;
    return w;
  endfunction

endpackage

// File: rtl/ext_bus_target_if.sv
// MCU external bus pins as seen between the host (master) and this target (slave).
interface ext_bus_target_if;
  logic [15:0] BUS_ADDR;
  logic [15:0] BUS_DIN;
  logic        BUS_RDN;
  logic        BUS_WRN0;
  logic        BUS_WRN1;
  logic [15:0] BUS_DOUT;
  logic        BUS_DOE;

  modport master (
    output BUS_ADDR, BUS_DIN, BUS_RDN, BUS_WRN0, BUS_WRN1,
    input  BUS_DOUT, BUS_DOE
  );

  modport slave (
    input  BUS_ADDR, BUS_DIN, BUS_RDN, BUS_WRN0, BUS_WRN1,
    output BUS_DOUT, BUS_DOE
  );
endinterface

// File: rtl/ext_bus_target_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module bus_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PUSH,
  input  logic [WIDTH-1:0]       PUSH_DATA,
  input  logic                   POP,
  output logic [WIDTH-1:0]       POP_DATA,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FULL,
  output logic                   EMPTY
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign FULL     = (count_q == (AW+1)'(DEPTH));
  assign EMPTY    = (count_q == '0);
  assign COUNT    = count_q;
  assign do_push  = PUSH && !FULL;
  assign do_pop   = POP && !EMPTY;
  // Head is forced to zero when empty so the local port never shows stale data.
  assign POP_DATA = EMPTY ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= PUSH_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ext_bus_target.sv
// External bus responder: synchronizes host strobes, decodes a 4-word window and
// bridges DATA accesses to the host-to-local and local-to-host FIFOs.
module ext_bus_target
  import ext_bus_target_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  ext_bus_target_if.slave   bus,
  output logic [15:0]       TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [15:0]       RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              IRQ
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Strobe vectors are {WRN1, WRN0, RDN}; they reset low so a held strobe never looks like a fresh fall.
  logic [2:0]  s1_stb, s2_stb, s3_stb;
  logic [15:0] s1_addr, s2_addr, s1_din, s2_din;
  logic        rd_fall_q, rd_rise_q, wr_fall_q, wr_rise_q;
  logic        rd, wr, rd_d, wr_d, s_hit;

  acc_state_t  state;
  logic [1:0]  reg_q, lanes_q;
  logic        hit_q, rd_empty_q, doe_q, ovf, udf, irq;
  logic [15:0] wdata_q, dout_q, scratch, rd_val, l2h_data;
  logic [2:0]  irq_en;

  logic          h2l_full, h2l_empty, l2h_full, l2h_empty;
  logic [CW-1:0] h2l_count, l2h_count;
  logic          commit, rd_done, h2l_push, l2h_pop, ovf_set, udf_set, ovf_clr, udf_clr;
  logic [15:0]   h2l_wdata;
  status_t       stat;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_stb  <= '0;
      s2_stb  <= '0;
      s3_stb  <= '0;
      s1_addr <= '0;
      s2_addr <= '0;
      s1_din  <= '0;
      s2_din  <= '0;
      rd_fall_q <= 1'b0;
      rd_rise_q <= 1'b0;
      wr_fall_q <= 1'b0;
      wr_rise_q <= 1'b0;
    end else begin
      s1_stb  <= {bus.BUS_WRN1, bus.BUS_WRN0, bus.BUS_RDN};
      s2_stb  <= s1_stb;
      s3_stb  <= s2_stb;
      s1_addr <= bus.BUS_ADDR;
      s2_addr <= s1_addr;
      s1_din  <= bus.BUS_DIN;
      s2_din  <= s1_din;
      rd_fall_q <= rd && !rd_d;
      rd_rise_q <= !rd && rd_d;
      wr_fall_q <= wr && !wr_d;
      wr_rise_q <= !wr && wr_d;
    end
  end

  assign rd    = !s2_stb[0];
  assign wr    = !s2_stb[1] || !s2_stb[2];
  assign rd_d  = !s3_stb[0];
  assign wr_d  = !s3_stb[1] || !s3_stb[2];
  assign s_hit = (s2_addr[15:2] == BASE_ADDR[15:2]);

  assign commit    = (state == S_WR) && wr_rise_q && hit_q;
  assign rd_done   = (state == S_RD) && rd_rise_q && hit_q;
  assign h2l_push  = commit && (reg_q == REG_DATA);
  assign h2l_wdata = {lanes_q[1] ? wdata_q[15:8] : 8'h00, lanes_q[0] ? wdata_q[7:0] : 8'h00};
  assign l2h_pop   = rd_done && (reg_q == REG_DATA) && !rd_empty_q;
  assign ovf_set   = h2l_push && h2l_full;
  assign udf_set   = rd_done && (reg_q == REG_DATA) && rd_empty_q;
  assign ovf_clr   = commit && (reg_q == REG_STATUS) && lanes_q[0] && wdata_q[ST_OVF];
  assign udf_clr   = commit && (reg_q == REG_STATUS) && lanes_q[0] && wdata_q[ST_UDF];

  assign stat = '{h2l_full: h2l_full, h2l_empty: h2l_empty, l2h_empty: l2h_empty,
                  l2h_full: l2h_full, ovf: ovf, udf: udf, l2h_count: 4'(l2h_count)};

  always_comb begin
    rd_val = '0;
    case (s2_addr[1:0])
      REG_DATA:    rd_val = l2h_data;
      REG_STATUS:  rd_val = status_word(stat);
      REG_IRQ_EN:  rd_val = {13'b0, irq_en};
      REG_SCRATCH: rd_val = scratch;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      reg_q      <= REG_DATA;
      hit_q      <= 1'b0;
      lanes_q    <= '0;
      wdata_q    <= '0;
      rd_empty_q <= 1'b0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
      scratch    <= '0;
      irq_en     <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= |(irq_en & {ovf || udf, h2l_empty, !l2h_empty});
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (udf_clr) udf <= 1'b0;

      case (state)
        S_IDLE: begin
          if (wr_fall_q) begin
            state   <= S_WR;
            reg_q   <= s2_addr[1:0];
            hit_q   <= s_hit;
            lanes_q <= {!s2_stb[2], !s2_stb[1]};
            wdata_q <= s2_din;
          end else if (rd_fall_q) begin
            state      <= S_RD;
            reg_q      <= s2_addr[1:0];
            hit_q      <= s_hit;
            rd_empty_q <= l2h_empty;
            if (s_hit) begin
              dout_q <= rd_val;
              doe_q  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (rd_rise_q) begin
            state  <= S_IDLE;
            dout_q <= '0;
            doe_q  <= 1'b0;
          end
        end
        S_WR: begin
          // Exit commits the sample held from the previous cycle, taken while the strobe was still low.
          if (wr_rise_q) begin
            state <= S_IDLE;
            if (commit && reg_q == REG_IRQ_EN && lanes_q[0]) irq_en <= wdata_q[2:0];
            if (commit && reg_q == REG_SCRATCH) begin
              if (lanes_q[0]) scratch[7:0]  <= wdata_q[7:0];
              if (lanes_q[1]) scratch[15:8] <= wdata_q[15:8];
            end
          end else begin
            lanes_q <= lanes_q | {!s2_stb[2], !s2_stb[1]};
            wdata_q <= s2_din;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  bus_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_h2l (
    .CLK(CLK), .RESET(RESET),
    .PUSH(h2l_push), .PUSH_DATA(h2l_wdata),
    .POP(TX_VALID && TX_READY), .POP_DATA(TX_DATA),
    .COUNT(h2l_count), .FULL(h2l_full), .EMPTY(h2l_empty)
  );

  bus_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_l2h (
    .CLK(CLK), .RESET(RESET),
    .PUSH(RX_VALID && RX_READY), .PUSH_DATA(RX_DATA),
    .POP(l2h_pop), .POP_DATA(l2h_data),
    .COUNT(l2h_count), .FULL(l2h_full), .EMPTY(l2h_empty)
  );

  assign TX_VALID     = !h2l_empty;
  assign RX_READY     = !l2h_full;
  assign IRQ          = irq;
  assign bus.BUS_DOUT = dout_q;
  assign bus.BUS_DOE  = doe_q;

  logic unused_h2l_count;
  assign unused_h2l_count = ^h2l_count;
endmodule

// File: tb/tb_ext_bus_target.sv
// Directed bench for ext_bus_target: register-access vector table plus timed host sequences.
module tb_ext_bus_target;
  localparam int unsigned DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [15:0] RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  ext_bus_target_if bif();

  ext_bus_target #(.BASE_ADDR(16'hF000), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bif),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  lanes;
    logic        exp_doe;
    logic [15:0] exp_dout;
  } vec_t;

  localparam int unsigned NV = 17;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes);
    @(posedge CLK); #1;
    bif.BUS_ADDR = a;
    bif.BUS_DIN  = d;
    repeat (2) @(posedge CLK);
    #1;
    bif.BUS_WRN0 = !lanes[0];
    bif.BUS_WRN1 = !lanes[1];
    repeat (6) @(posedge CLK);
    #1;
    bif.BUS_WRN0 = 1'b1;
    bif.BUS_WRN1 = 1'b1;
    repeat (8) @(posedge CLK);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic doe);
    @(posedge CLK); #1;
    bif.BUS_ADDR = a;
    repeat (2) @(posedge CLK);
    #1;
    bif.BUS_RDN = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    d   = bif.BUS_DOUT;
    doe = bif.BUS_DOE;
    @(posedge CLK); #1;
    bif.BUS_RDN = 1'b1;
    repeat (8) @(posedge CLK);
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        doe;
    bus_read(a, d, doe);
    check({name, "_doe"}, {31'b0, doe}, 32'd1);
    check(name, {16'b0, d}, {16'b0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic        doe;
    logic        doe_seen;

    vt[0]  = '{1'b0, 16'hF001, 16'h0000, 2'b00, 1'b1, 16'h0006};
    vt[1]  = '{1'b1, 16'hF003, 16'hFFFF, 2'b11, 1'b0, 16'h0000};
    vt[2]  = '{1'b0, 16'hF003, 16'h0000, 2'b00, 1'b1, 16'hFFFF};
    vt[3]  = '{1'b1, 16'hF003, 16'h1234, 2'b10, 1'b0, 16'h0000};
    vt[4]  = '{1'b0, 16'hF003, 16'h0000, 2'b00, 1'b1, 16'h12FF};
    vt[5]  = '{1'b1, 16'hF003, 16'h3356, 2'b01, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 16'hF003, 16'h0000, 2'b00, 1'b1, 16'h1256};
    vt[7]  = '{1'b1, 16'hF002, 16'hFFFF, 2'b11, 1'b0, 16'h0000};
    vt[8]  = '{1'b0, 16'hF002, 16'h0000, 2'b00, 1'b1, 16'h0007};
    vt[9]  = '{1'b1, 16'hF002, 16'hFF00, 2'b11, 1'b0, 16'h0000};
    vt[10] = '{1'b0, 16'hF002, 16'h0000, 2'b00, 1'b1, 16'h0000};
    vt[11] = '{1'b0, 16'hE003, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vt[12] = '{1'b0, 16'hF004, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vt[13] = '{1'b1, 16'hF000, 16'hA55A, 2'b11, 1'b0, 16'h0000};
    vt[14] = '{1'b1, 16'hF000, 16'h3377, 2'b01, 1'b0, 16'h0000};
    vt[15] = '{1'b1, 16'hE000, 16'h9999, 2'b11, 1'b0, 16'h0000};
    vt[16] = '{1'b0, 16'hF001, 16'h0000, 2'b00, 1'b1, 16'h0004};

    bif.BUS_ADDR = '0;
    bif.BUS_DIN  = '0;
    bif.BUS_RDN  = 1'b1;
    bif.BUS_WRN0 = 1'b1;
    bif.BUS_WRN1 = 1'b1;
    TX_READY = 1'b0;
    RX_DATA  = '0;
    RX_VALID = 1'b0;
    RESET    = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("rst_dout", {16'b0, bif.BUS_DOUT}, 32'h0);
    check("rst_doe", {31'b0, bif.BUS_DOE}, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_tx_valid", {31'b0, TX_VALID}, 32'h0);
    check("rst_tx_data", {16'b0, TX_DATA}, 32'h0);
    check("rst_rx_ready", {31'b0, RX_READY}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].is_wr) begin
        bus_write(vt[i].addr, vt[i].din, vt[i].lanes);
      end else begin
        bus_read(vt[i].addr, d, doe);
        check($sformatf("vec%0d_doe", i), {31'b0, doe}, {31'b0, vt[i].exp_doe});
        check($sformatf("vec%0d_dout", i), {16'b0, d}, {16'b0, vt[i].exp_dout});
      end
    end

    // H2L contents from the table: A55A then 0077 (high lane unwritten).
    @(negedge CLK);
    check("tx_valid0", {31'b0, TX_VALID}, 32'h1);
    check("tx_data0", {16'b0, TX_DATA}, 32'h0000A55A);
    @(posedge CLK); #1 TX_READY = 1'b1;
    @(posedge CLK); #1 TX_READY = 1'b0;
    @(negedge CLK);
    check("tx_data1", {16'b0, TX_DATA}, 32'h00000077);
    @(posedge CLK); #1 TX_READY = 1'b1;
    @(posedge CLK); #1 TX_READY = 1'b0;
    @(negedge CLK);
    check("tx_valid_drained", {31'b0, TX_VALID}, 32'h0);

    @(posedge CLK); #1 RX_DATA = 16'h1234; RX_VALID = 1'b1;
    @(posedge CLK); #1 RX_VALID = 1'b0;
    read_check("status_rx1", 16'hF001, 16'h0102);
    read_check("data_rx1", 16'hF000, 16'h1234);
    read_check("status_rx_popped", 16'hF001, 16'h0006);

    // Read latency and DOE release, counted from the strobe change.
    @(posedge CLK); #1 bif.BUS_ADDR = 16'hF003;
    repeat (2) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("lat_doe_e3", {31'b0, bif.BUS_DOE}, 32'h0);
    @(posedge CLK); @(negedge CLK);
    check("lat_doe_e4", {31'b0, bif.BUS_DOE}, 32'h1);
    check("lat_dout_e4", {16'b0, bif.BUS_DOUT}, 32'h00001256);
    repeat (3) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rel_doe_e3", {31'b0, bif.BUS_DOE}, 32'h1);
    @(posedge CLK); @(negedge CLK);
    check("rel_doe_e4", {31'b0, bif.BUS_DOE}, 32'h0);
    check("rel_dout_e4", {16'b0, bif.BUS_DOUT}, 32'h0);
    repeat (6) @(posedge CLK);

    for (int i = 0; i <= DEPTH; i++) bus_write(16'hF000, 16'h0100 + 16'(i), 2'b11);
    read_check("status_ovf", 16'hF001, 16'h0015);
    @(negedge CLK);
    check("ovf_head", {16'b0, TX_DATA}, 32'h00000100);
    bus_write(16'hF001, 16'h0010, 2'b11);
    read_check("status_ovf_clr", 16'hF001, 16'h0005);
    @(posedge CLK); #1 TX_READY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      check($sformatf("drain%0d", i), {15'b0, TX_VALID, TX_DATA}, {15'b0, 1'b1, 16'h0100 + 16'(i)});
      @(posedge CLK);
    end
    #1 TX_READY = 1'b0;
    @(negedge CLK);
    check("drain_empty", {31'b0, TX_VALID}, 32'h0);

    bus_write(16'hF002, 16'h0004, 2'b11);
    @(negedge CLK);
    check("irq_before_udf", {31'b0, IRQ}, 32'h0);
    @(posedge CLK); #1 bif.BUS_ADDR = 16'hF000;
    repeat (2) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("udf_doe", {31'b0, bif.BUS_DOE}, 32'h1);
    check("udf_dout", {16'b0, bif.BUS_DOUT}, 32'h0);
    @(posedge CLK); #1 bif.BUS_RDN = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("irq_at_exit", {31'b0, IRQ}, 32'h0);
    @(posedge CLK); @(negedge CLK);
    check("irq_after_exit", {31'b0, IRQ}, 32'h1);
    repeat (4) @(posedge CLK);
    read_check("status_udf", 16'hF001, 16'h0026);
    bus_write(16'hF001, 16'h0020, 2'b11);
    @(negedge CLK);
    check("irq_udf_clr", {31'b0, IRQ}, 32'h0);
    bus_write(16'hF002, 16'h0000, 2'b11);

    // RDN and WRN0 fall together: write wins, no read drive.
    doe_seen = 1'b0;
    @(posedge CLK); #1 bif.BUS_ADDR = 16'hF003; bif.BUS_DIN = 16'hABCD;
    repeat (2) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b0; bif.BUS_WRN0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      doe_seen = doe_seen | bif.BUS_DOE;
    end
    @(posedge CLK); #1 bif.BUS_RDN = 1'b1; bif.BUS_WRN0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      doe_seen = doe_seen | bif.BUS_DOE;
    end
    check("simul_doe", {31'b0, doe_seen}, 32'h0);
    read_check("simul_scratch", 16'hF003, 16'h12CD);

    for (int i = 0; i <= DEPTH; i++) begin
      @(posedge CLK); #1 RX_DATA = 16'h0200 + 16'(i); RX_VALID = 1'b1;
    end
    @(posedge CLK); #1 RX_VALID = 1'b0;
    @(negedge CLK);
    check("l2h_full_ready", {31'b0, RX_READY}, 32'h0);
    read_check("status_l2h_full", 16'hF001, 16'h080A);
    for (int i = 0; i < DEPTH - 2; i++)
      read_check($sformatf("l2h_pop%0d", i), 16'hF000, 16'h0200 + 16'(i));
    @(negedge CLK);
    check("l2h_ready_again", {31'b0, RX_READY}, 32'h1);
    read_check("status_l2h_two", 16'hF001, 16'h0202);

    // Reset while a DATA read is in flight with two L2H entries queued.
    @(posedge CLK); #1 bif.BUS_ADDR = 16'hF000;
    repeat (2) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b0;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    check("mid_doe", {31'b0, bif.BUS_DOE}, 32'h1);
    check("mid_dout", {16'b0, bif.BUS_DOUT}, 32'h00000206);
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_doe", {31'b0, bif.BUS_DOE}, 32'h0);
    check("rst_mid_dout", {16'b0, bif.BUS_DOUT}, 32'h0);
    repeat (4) @(posedge CLK);
    #1 bif.BUS_RDN = 1'b1;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("rst_rise_doe", {31'b0, bif.BUS_DOE}, 32'h0);
    check("rst_rise_irq", {31'b0, IRQ}, 32'h0);
    read_check("status_after_rst", 16'hF001, 16'h0006);
    read_check("scratch_after_rst", 16'hF003, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
